// File: rtl/pkt_dmem_loader.sv
// Store-process-forward packet buffer in front of the cpu: captures one packet,
// lends the buffer to the cpu as packet memory, then streams it downstream.
module pkt_dmem_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  input  logic                  cpu_we,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  cpu_done,
  output logic                  pkt_ready,
  output logic [ADDR_WIDTH-1:0] pkt_len,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_PROC = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Data and ctrl are kept in separate arrays so cpu writes leave ctrl untouched.
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [CTRL_WIDTH-1:0] r_mem_ctrl [DEPTH];

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic                  r_full;
  logic                  r_seen_data;
  logic [ADDR_WIDTH-1:0] r_pkt_len;
  logic                  r_in_rdy;
  logic                  r_pkt_ready;
  logic [ADDR_WIDTH-1:0] r_fptr;
  logic                  r_fetch_done;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic                  r_pf_valid;
  logic [DATA_WIDTH-1:0] r_pf_data;
  logic [CTRL_WIDTH-1:0] r_pf_ctrl;
  logic [DATA_WIDTH-1:0] r_cpu_dout;
  logic [31:0]           r_pkt_count;
  logic [31:0]           r_drop_count;

  logic w_accept;
  logic w_ctrl_nz;
  logic w_eop;
  logic w_store;
  logic w_fire;
  logic w_last;
  logic w_load;
  logic w_cpu_wr;

  assign w_accept  = in_wr & r_in_rdy;
  assign w_ctrl_nz = |in_ctrl;
  assign w_eop     = w_accept & r_seen_data & w_ctrl_nz;
  assign w_store   = w_accept & ~r_full;
  assign w_fire    = (r_state == S_SEND) & r_pf_valid & out_rdy;
  assign w_last    = w_fire & (r_rptr == r_pkt_len);
  assign w_load    = (r_state == S_SEND) & ~r_fetch_done & (~r_pf_valid | w_fire);
  assign w_cpu_wr  = (r_state == S_PROC) & cpu_we;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = w_eop ? S_PROC : S_RECV;
        else          w_next_state = S_IDLE;
      end
      S_RECV: begin
        if (w_eop) w_next_state = S_PROC;
        else       w_next_state = S_RECV;
      end
      S_PROC: begin
        if (cpu_done) w_next_state = S_SEND;
        else          w_next_state = S_PROC;
      end
      S_SEND: begin
        if (w_last) w_next_state = S_IDLE;
        else        w_next_state = S_SEND;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Buffer writes: port A during receive, port B (data bits only) during PROC
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_data[r_wptr] <= in_data;
      r_mem_ctrl[r_wptr] <= in_ctrl;
    end else if (w_cpu_wr) begin
      r_mem_data[cpu_addr] <= cpu_din;
    end
  end

  // cpu read port, write-first so a just-written word reads back its new value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_cpu_dout <= {DATA_WIDTH{1'b0}};
    else if (r_state == S_PROC)  r_cpu_dout <= w_cpu_wr ? cpu_din : r_mem_data[cpu_addr];
  end

  // Receive pointer, handshakes and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr       <= {ADDR_WIDTH{1'b0}};
      r_full       <= 1'b0;
      r_seen_data  <= 1'b0;
      r_pkt_len    <= {ADDR_WIDTH{1'b0}};
      r_in_rdy     <= 1'b0;
      r_pkt_ready  <= 1'b0;
      r_pkt_count  <= 32'd0;
      r_drop_count <= 32'd0;
    end else begin
      r_in_rdy    <= (w_next_state == S_RECV) | ((w_next_state == S_IDLE) & enable);
      r_pkt_ready <= (w_next_state == S_PROC);
      if (w_store) begin
        if (&r_wptr) begin
          r_full    <= 1'b1;
          r_pkt_len <= '1;
        end else begin
          r_wptr <= r_wptr + ADDR_WIDTH'(1);
        end
      end
      if (w_accept & ~w_ctrl_nz) r_seen_data <= 1'b1;
      // End of packet rearms the receive side for the next packet.
      if (w_eop) begin
        r_pkt_len   <= r_full ? {ADDR_WIDTH{1'b1}} : r_wptr;
        r_wptr      <= {ADDR_WIDTH{1'b0}};
        r_full      <= 1'b0;
        r_seen_data <= 1'b0;
        if (r_full) r_drop_count <= r_drop_count + 32'd1;
      end
      if (w_last) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  // Send-side prefetch: one buffered word ahead of the downstream handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fptr       <= {ADDR_WIDTH{1'b0}};
      r_fetch_done <= 1'b0;
      r_rptr       <= {ADDR_WIDTH{1'b0}};
      r_pf_valid   <= 1'b0;
      r_pf_data    <= {DATA_WIDTH{1'b0}};
      r_pf_ctrl    <= {CTRL_WIDTH{1'b0}};
    end else if ((r_state == S_PROC) && cpu_done) begin
      r_fptr       <= {ADDR_WIDTH{1'b0}};
      r_fetch_done <= 1'b0;
      r_rptr       <= {ADDR_WIDTH{1'b0}};
      r_pf_valid   <= 1'b0;
    end else begin
      if (w_fire) r_rptr <= r_rptr + ADDR_WIDTH'(1);
      if (w_load) begin
        r_pf_data  <= r_mem_data[r_fptr];
        r_pf_ctrl  <= r_mem_ctrl[r_fptr];
        r_pf_valid <= 1'b1;
        if (r_fptr == r_pkt_len) r_fetch_done <= 1'b1;
        else                     r_fptr <= r_fptr + ADDR_WIDTH'(1);
      end else if (w_fire) begin
        r_pf_valid <= 1'b0;
      end
    end
  end

  assign in_rdy     = r_in_rdy;
  assign out_wr     = w_fire;
  assign out_data   = r_pf_data;
  assign out_ctrl   = r_pf_ctrl;
  assign cpu_dout   = r_cpu_dout;
  assign pkt_ready  = r_pkt_ready;
  assign pkt_len    = r_pkt_len;
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pkt_dmem_loader.sv
// Directed bench for pkt_dmem_loader: capture, cpu access, overflow,
// backpressure, enable gating and asynchronous reset during send.
module tb_pkt_dmem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        enable;
  logic [7:0]  cpu_addr;
  logic [63:0] cpu_din;
  logic        cpu_we;
  logic [63:0] cpu_dout;
  logic        cpu_done;
  logic        pkt_ready;
  logic [7:0]  pkt_len;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] stim_data [0:299];
  logic [7:0]  stim_ctrl [0:299];
  logic [63:0] got_data [$];
  logic [7:0]  got_ctrl [$];
  int          viol;
  bit          timed_out;

  always #5 clk = ~clk;

  pkt_dmem_loader dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .enable(enable),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cpu_done(cpu_done), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pkt(input int n, input logic [31:0] tag);
    for (int i = 0; i < n; i++) begin
      stim_data[i] = {tag, 32'(i)};
      stim_ctrl[i] = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h80 : 8'h00);
    end
  endtask

  task automatic drive_pkt(input int n, input int drop_en_at, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      while (!in_rdy && guard < 50) begin
        in_wr = 1'b0;
        tick();
        guard++;
        if (i > 0) stalls++;
      end
      if (guard >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: in_rdy low at word %0d, required 1", i);
      end
      if (i == drop_en_at) enable = 1'b0;
      in_data = stim_data[i];
      in_ctrl = stim_ctrl[i];
      in_wr   = 1'b1;
      tick();
    end
    in_wr = 1'b0;
  endtask

  task automatic collect(input int n, input bit use_pattern);
    logic [5:0] pat;
    int k;
    pat = 6'b011001;
    k = 0;
    got_data.delete();
    got_ctrl.delete();
    viol = 0;
    timed_out = 1'b0;
    while (got_data.size() < n && k < 2000) begin
      out_rdy = use_pattern ? pat[k % 6] : 1'b1;
      #2;
      if (out_wr) begin
        if (!out_rdy) viol++;
        got_data.push_back(out_data);
        got_ctrl.push_back(out_ctrl);
      end
      @(posedge clk);
      #1;
      k++;
    end
    out_rdy = 1'b1;
    if (got_data.size() < n) timed_out = 1'b1;
  endtask

  task automatic pulse_done();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_checks++;
    if (in_rdy !== 1'b0 || out_wr !== 1'b0 || pkt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_rdy=%b out_wr=%b pkt_ready=%b, required 0 0 0", in_rdy, out_wr, pkt_ready);
    end
    n_checks++;
    if (out_data !== 64'd0 || out_ctrl !== 8'd0 || cpu_dout !== 64'd0 || pkt_len !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h out_ctrl=%h cpu_dout=%h pkt_len=%0d, required all 0", out_data, out_ctrl, cpu_dout, pkt_len);
    end
    n_checks++;
    if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: pkt_count=%0d drop_count=%0d, required 0 0", pkt_count, drop_count);
    end
    #10;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int stalls;
    fill_pkt(5, 32'hA1A1_0000);
    drive_pkt(5, -1, stalls);
    n_checks++;
    if (pkt_len !== 8'd4) begin n_fail++; $display("FAIL basic_pkt_len: got %0d, required 4", pkt_len); end
    n_checks++;
    if (pkt_ready !== 1'b1 || in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_proc_flags: pkt_ready=%b in_rdy=%b, required 1 0", pkt_ready, in_rdy);
    end
    pulse_done();
    n_checks++;
    if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: pkt_ready=%b, required 0", pkt_ready); end
    collect(5, 1'b0);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL basic_count: got %0d words, required 5", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== stim_data[i] || got_ctrl[i] !== stim_ctrl[i]) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h/%h, required %h/%h", i, got_ctrl[i], got_data[i], stim_ctrl[i], stim_data[i]);
      end
    end
    n_checks++;
    if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL basic_pkt_count: got %0d, required 1", pkt_count); end
  endtask

  task automatic test_cpu_write();
    int stalls;
    fill_pkt(5, 32'hB2B2_0000);
    drive_pkt(5, -1, stalls);
    cpu_addr = 8'd2;
    cpu_din  = 64'hDEADBEEF_00000000;
    cpu_we   = 1'b1;
    tick();
    cpu_we = 1'b0;
    tick();
    n_checks++;
    if (cpu_dout !== 64'hDEADBEEF_00000000) begin
      n_fail++;
      $display("FAIL cpu_readback: got %h, required %h", cpu_dout, 64'hDEADBEEF_00000000);
    end
    cpu_addr = 8'd0;
    tick();
    n_checks++;
    if (cpu_dout !== stim_data[0]) begin
      n_fail++;
      $display("FAIL cpu_read_word0: got %h, required %h", cpu_dout, stim_data[0]);
    end
    // write coinciding with cpu_done must land; writes during SEND must not
    cpu_addr = 8'd1;
    cpu_din  = 64'h1111_2222_3333_4444;
    cpu_we   = 1'b1;
    pulse_done();
    cpu_addr = 8'd3;
    cpu_din  = 64'hBAD0_BAD0_BAD0_BAD0;
    collect(5, 1'b0);
    cpu_we = 1'b0;
    stim_data[1] = 64'h1111_2222_3333_4444;
    stim_data[2] = 64'hDEADBEEF_00000000;
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL cpu_count: got %0d words, required 5", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== stim_data[i] || got_ctrl[i] !== stim_ctrl[i]) begin
        n_fail++;
        $display("FAIL cpu_word%0d: got %h/%h, required %h/%h", i, got_ctrl[i], got_data[i], stim_ctrl[i], stim_data[i]);
      end
    end
    n_checks++;
    if (pkt_count !== 32'd2) begin n_fail++; $display("FAIL cpu_pkt_count: got %0d, required 2", pkt_count); end
  endtask

  task automatic test_overflow();
    int stalls;
    int extra;
    fill_pkt(300, 32'hC3C3_0000);
    drive_pkt(300, -1, stalls);
    n_checks++;
    if (stalls !== 0) begin n_fail++; $display("FAIL ovf_in_rdy: %0d stall cycles, required 0", stalls); end
    n_checks++;
    if (pkt_len !== 8'd255) begin n_fail++; $display("FAIL ovf_pkt_len: got %0d, required 255", pkt_len); end
    n_checks++;
    if (drop_count !== 32'd1) begin n_fail++; $display("FAIL ovf_drop_count: got %0d, required 1", drop_count); end
    pulse_done();
    collect(256, 1'b0);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL ovf_count: got %0d words, required 256", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== stim_data[i] || got_ctrl[i] !== stim_ctrl[i]) begin
        n_fail++;
        $display("FAIL ovf_word%0d: got %h/%h, required %h/%h", i, got_ctrl[i], got_data[i], stim_ctrl[i], stim_data[i]);
      end
    end
    if (got_ctrl.size() == 256) begin
      n_checks++;
      if (got_ctrl[255] !== 8'h00) begin n_fail++; $display("FAIL ovf_last_ctrl: got %h, required 00", got_ctrl[255]); end
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (out_wr) extra++;
      tick();
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL ovf_extra_words: got %0d, required 0", extra); end
    n_checks++;
    if (pkt_count !== 32'd3) begin n_fail++; $display("FAIL ovf_pkt_count: got %0d, required 3", pkt_count); end
  endtask

  task automatic test_back_to_back();
    int stalls;
    fill_pkt(5, 32'hD4D4_0000);
    drive_pkt(5, -1, stalls);
    pulse_done();
    collect(5, 1'b1);
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL bp_out_wr_gating: %0d writes with out_rdy low, required 0", viol); end
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL bp_count: got %0d words, required 5", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== stim_data[i] || got_ctrl[i] !== stim_ctrl[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %h/%h, required %h/%h", i, got_ctrl[i], got_data[i], stim_ctrl[i], stim_data[i]);
      end
    end
    n_checks++;
    if (pkt_count !== 32'd4) begin n_fail++; $display("FAIL bp_pkt_count: got %0d, required 4", pkt_count); end
  endtask

  task automatic test_enable();
    int stalls;
    enable = 1'b0;
    tick();
    tick();
    n_checks++;
    if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL en_idle_in_rdy: got %b, required 0", in_rdy); end
    in_data = 64'h5555_5555_5555_5555;
    in_ctrl = 8'h00;
    in_wr   = 1'b1;
    tick();
    tick();
    tick();
    in_wr  = 1'b0;
    enable = 1'b1;
    fill_pkt(5, 32'hE5E5_0000);
    drive_pkt(5, 2, stalls);
    n_checks++;
    if (pkt_len !== 8'd4 || pkt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL en_recv_complete: pkt_len=%0d pkt_ready=%b, required 4 1", pkt_len, pkt_ready);
    end
    pulse_done();
    collect(5, 1'b0);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL en_count: got %0d words, required 5", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== stim_data[i] || got_ctrl[i] !== stim_ctrl[i]) begin
        n_fail++;
        $display("FAIL en_word%0d: got %h/%h, required %h/%h", i, got_ctrl[i], got_data[i], stim_ctrl[i], stim_data[i]);
      end
    end
    n_checks++;
    if (pkt_count !== 32'd5 || in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_after: pkt_count=%0d in_rdy=%b, required 5 0", pkt_count, in_rdy);
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_send();
    int stalls;
    int cnt;
    int k;
    fill_pkt(5, 32'hF6F6_0000);
    drive_pkt(5, -1, stalls);
    pulse_done();
    out_rdy = 1'b1;
    cnt = 0;
    k = 0;
    while (cnt < 2 && k < 50) begin
      #2;
      if (out_wr) cnt++;
      if (cnt < 2) tick();
      k++;
    end
    n_checks++;
    if (cnt < 2) begin n_fail++; $display("FAIL rst_send_timeout: got %0d words, required 2", cnt); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_wr !== 1'b0 || pkt_count !== 32'd0 || drop_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_async_clear: out_wr=%b pkt_count=%0d drop_count=%0d, required 0 0 0", out_wr, pkt_count, drop_count);
    end
    n_checks++;
    if (pkt_ready !== 1'b0 || in_rdy !== 1'b0 || out_data !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_async_flags: pkt_ready=%b in_rdy=%b out_data=%h, required 0 0 0", pkt_ready, in_rdy, out_data);
    end
    #3;
    reset = 1'b1;
    tick();
    fill_pkt(5, 32'h0707_0000);
    drive_pkt(5, -1, stalls);
    n_checks++;
    if (pkt_len !== 8'd4) begin n_fail++; $display("FAIL rst_next_pkt_len: got %0d, required 4", pkt_len); end
    pulse_done();
    collect(5, 1'b0);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL rst_next_count: got %0d words, required 5", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== stim_data[i] || got_ctrl[i] !== stim_ctrl[i]) begin
        n_fail++;
        $display("FAIL rst_next_word%0d: got %h/%h, required %h/%h", i, got_ctrl[i], got_data[i], stim_ctrl[i], stim_data[i]);
      end
    end
    n_checks++;
    if (pkt_count !== 32'd1) begin n_fail++; $display("FAIL rst_next_pkt_count: got %0d, required 1", pkt_count); end
  endtask

  initial begin
    in_data  = 64'd0;
    in_ctrl  = 8'd0;
    in_wr    = 1'b0;
    out_rdy  = 1'b1;
    enable   = 1'b1;
    cpu_addr = 8'd0;
    cpu_din  = 64'd0;
    cpu_we   = 1'b0;
    cpu_done = 1'b0;
    test_reset();
    test_basic();
    test_cpu_write();
    test_overflow();
    test_back_to_back();
    test_enable();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_dmem_loader.md
Name: pkt_dmem_loader

Overview:
- Packet-capture stage directly upstream of the cpu core on the 64-bit NetFPGA user datapath.
- Receives one packet from the upstream module into a 256x72 buffer (64 data + 8 ctrl bits).
- Hands the buffer to the cpu as its packet memory, waits for cpu_done, then streams the possibly modified packet downstream.
- Replaces the pass-through wiring around the cpu with store–process–forward operation.

Parameters:
- DATA_WIDTH, 64, datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl byte-lane width.
- ADDR_WIDTH, 8, buffer address width (depth 2**ADDR_WIDTH = 256 words).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  upstream packet word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl; nonzero on module-header words and on the last word.
- in_wr  in  1  upstream word valid.
- in_rdy  out  1  block accepts words.
- out_data  out  DATA_WIDTH  downstream packet word.
- out_ctrl  out  CTRL_WIDTH  downstream ctrl.
- out_wr  out  1  downstream word valid.
- out_rdy  in  1  downstream can accept.
- enable  in  1  0 = block refuses new packets (in_rdy=0); packets already in flight complete.
- cpu_addr  in  ADDR_WIDTH  cpu packet-memory address.
- cpu_din  in  DATA_WIDTH  cpu write data.
- cpu_we  in  1  cpu write strobe; honoured only in PROC.
- cpu_dout  out  DATA_WIDTH  cpu read data, registered, 1-cycle latency.
- cpu_done  in  1  one-cycle pulse, packet processing finished.
- pkt_ready  out  1  high throughout PROC.
- pkt_len  out  ADDR_WIDTH  index of last stored word (word count minus 1).
- pkt_count  out  32  packets forwarded, wraps.
- drop_count  out  32  packets truncated by overflow, wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - in_rdy=0, out_wr=0, out_data=0, out_ctrl=0, pkt_ready=0, pkt_len=0, cpu_dout=0, counters=0.
  - Buffer contents undefined.
- IDLE:
  - in_rdy=enable.
  - A word with in_wr&in_rdy is written to addr 0 and the state moves to RECV.
  - If that word's ctrl qualifies as EOP (see RECV), the state moves to PROC instead.
- RECV:
  - in_rdy=1.
  - Each in_wr stores {in_ctrl,in_data} at wptr, then wptr increments.
  - seen_data is set by any word with in_ctrl==0.
  - EOP = in_wr & seen_data & in_ctrl!=0. On EOP, pkt_len<=wptr and the state moves to PROC.
- Overflow:
  - Once wptr reaches 255 without EOP, further words are accepted and discarded and pkt_len=255.
  - On the eventual EOP: drop_count+1, the state moves to PROC, and word 255 holds the last stored word (not the EOP word).
- PROC:
  - in_rdy=0, pkt_ready=1.
  - Buffer port B belongs to the cpu; cpu_dout updates every cycle from cpu_addr.
  - cpu_done moves the state to SEND and resets rptr to 0.
  - cpu_we when not in PROC is ignored.
- SEND:
  - Prefetch register holds buf[rptr].
  - In any cycle with out_rdy=1 and word available: out_wr=1 with out_data/out_ctrl presented, and rptr advances.
  - The word at pkt_len is sent last; next cycle the state returns to IDLE with pkt_count+1.
  - out_wr is never high while out_rdy is low.
  - Minimum: one word per cycle after 1 cycle of prefetch latency.
- Simultaneous events:
  - A cpu_done coinciding with cpu_we commits the write before SEND reads it.
  - The cpu writes ctrl lanes only indirectly: stored ctrl is preserved; cpu_din replaces data bits only.
- enable deasserted mid-RECV: the packet still completes. Reset mid-operation: the packet is lost, counters clear.
- Buffer: true dual-port; port A = receive write / send read, port B = cpu. Inferred block RAM.

Test Plan:
- Header ctrl=0xFF, 3 data words ctrl=0, last word ctrl=0x80 (5 words total):
  - pkt_len=4, pkt_ready=1.
  - After cpu_done, 5 identical words out in order with original ctrl; pkt_count=1.
- In PROC, cpu writes 0xDEADBEEF_00000000 at addr 2, reads addr 2:
  - cpu_dout equals written value one cycle later.
  - Forwarded word 2 carries new data with ctrl=0x00.
- 300-word packet:
  - in_rdy stays 1 and pkt_len=255.
  - drop_count=1; 256 words forwarded, last ctrl=0x00.
- out_rdy toggled 1,0,0,1,1,0 during SEND:
  - out_wr only in out_rdy=1 cycles.
  - No duplicated or skipped words; order preserved.
- enable=0 in IDLE: in_rdy=0, upstream word not accepted. Set enable=0 during RECV: the current packet completes normally.
- Assert reset low asynchronously (between clk edges) mid-SEND:
  - Outputs clear immediately (out_wr=0, pkt_count=0).
  - Next packet is received correctly from addr 0.
